// File: rtl/instr_fetch.sv
// Instruction fetch stage: assembles 16-bit words from an 8-bit memory,
// keeps the last word in a one-entry address-tagged buffer.
module instr_fetch (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] pc,
   input  logic        fetch_en,
   output logic [15:0] instr,
   output logic        instr_valid,
   output logic        stall,
   output logic        misalign,
   output logic [15:0] mem_addr,
   output logic        mem_req,
   input  logic        mem_ack,
   input  logic [7:0]  mem_rdata
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ_LO = 2'd1,
      REQ_HI = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] fetch_addr_q, fetch_addr_d;
   logic [15:0] mem_addr_q, mem_addr_d;
   logic        mem_req_q, mem_req_d;
   logic [7:0]  lo_byte_q, lo_byte_d;
   logic [15:0] buf_addr_q, buf_addr_d;
   logic [15:0] buf_data_q, buf_data_d;
   logic        buf_valid_q, buf_valid_d;
   logic        misalign_q, misalign_d;

   logic        hit;
   logic        miss;

   assign hit  = buf_valid_q & (buf_addr_q == pc);
   assign miss = fetch_en & ~hit & ~pc[0];

   assign instr       = buf_data_q;
   assign instr_valid = hit;
   assign stall       = miss & ~reset;
   assign misalign    = misalign_q;
   assign mem_addr    = mem_addr_q;
   assign mem_req     = mem_req_q;

   always_comb begin
      state_d      = state_q;
      fetch_addr_d = fetch_addr_q;
      mem_addr_d   = mem_addr_q;
      mem_req_d    = mem_req_q;
      lo_byte_d    = lo_byte_q;
      buf_addr_d   = buf_addr_q;
      buf_data_d   = buf_data_q;
      buf_valid_d  = buf_valid_q;
      misalign_d   = misalign_q | (fetch_en & pc[0]);

      // A started fetch always runs to completion, whatever pc does.
      unique case (state_q)
         IDLE: begin
            mem_req_d = 1'b0;
            if (miss) begin
               fetch_addr_d = pc;
               mem_addr_d   = pc;
               mem_req_d    = 1'b1;
               state_d      = REQ_LO;
            end
         end
         REQ_LO: begin
            if (mem_ack) begin
               lo_byte_d  = mem_rdata;
               mem_addr_d = fetch_addr_q + 16'd1;
               state_d    = REQ_HI;
            end
         end
         REQ_HI: begin
            if (mem_ack) begin
               buf_data_d  = {mem_rdata, lo_byte_q};
               buf_addr_d  = fetch_addr_q;
               buf_valid_d = 1'b1;
               mem_req_d   = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            mem_req_d = 1'b0;
            state_d   = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         fetch_addr_q <= 16'd0;
         mem_addr_q   <= 16'd0;
         mem_req_q    <= 1'b0;
         lo_byte_q    <= 8'd0;
         buf_addr_q   <= 16'd0;
         buf_data_q   <= 16'd0;
         buf_valid_q  <= 1'b0;
         misalign_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         fetch_addr_q <= fetch_addr_d;
         mem_addr_q   <= mem_addr_d;
         mem_req_q    <= mem_req_d;
         lo_byte_q    <= lo_byte_d;
         buf_addr_q   <= buf_addr_d;
         buf_data_q   <= buf_data_d;
         buf_valid_q  <= buf_valid_d;
         misalign_q   <= misalign_d;
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: transaction-level model, byte memory with
// random wait states, directed scenarios then a randomized run.
module tb_instr_fetch;

   logic        clock = 1'b0;
   logic        reset;
   logic [15:0] pc;
   logic        fetch_en;
   logic [15:0] instr;
   logic        instr_valid;
   logic        stall;
   logic        misalign;
   logic [15:0] mem_addr;
   logic        mem_req;
   logic        mem_ack;
   logic [7:0]  mem_rdata;

   instr_fetch dut (
      .clock       (clock),
      .reset       (reset),
      .pc          (pc),
      .fetch_en    (fetch_en),
      .instr       (instr),
      .instr_valid (instr_valid),
      .stall       (stall),
      .misalign    (misalign),
      .mem_addr    (mem_addr),
      .mem_req     (mem_req),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata)
   );

   always #5 clock = ~clock;

   logic [7:0]  mem [0:65535];
   int          checks = 0;
   int          failures = 0;
   bit          chk_en = 0;

   // model: outstanding fetch + buffer contents
   bit          m_busy;
   int          m_n;
   logic [15:0] m_faddr, m_maddr, m_bdata, m_baddr;
   logic [7:0]  m_lo;
   bit          m_bvalid, m_mis;

   int          ws = -1;
   int          max_wait = 0;
   int          wq[$];
   bit          idle_acks = 0;
   logic [15:0] alog[$];
   int          req_cnt = 0;
   bit          o_stall, o_valid;
   logic [15:0] o_instr;

   task automatic chk(input string nm, input logic [15:0] act,
                      input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_n = 0; m_faddr = 0; m_maddr = 0;
      m_bdata = 0; m_baddr = 0; m_lo = 0; m_bvalid = 0; m_mis = 0;
   endtask

   task automatic cycle(input logic rst, input logic [15:0] p,
                        input logic fe);
      logic        hm;
      logic [15:0] a1;
      @(negedge clock);
      reset = rst; pc = p; fetch_en = fe;
      mem_ack = 1'b0; mem_rdata = 8'($urandom);
      if (mem_req === 1'b1) begin
         if (ws < 0)
            ws = (wq.size() > 0) ? wq.pop_front()
                                 : int'($urandom_range(0, max_wait));
         if (ws == 0) begin
            mem_ack = 1'b1;
            mem_rdata = mem[mem_addr];
            alog.push_back(mem_addr);
            ws = -1;
         end else ws--;
      end else begin
         ws = -1;
         if (idle_acks) mem_ack = ($urandom % 3 == 0);
      end
      #1;
      hm = m_bvalid && (m_baddr == p);
      if (chk_en) begin
         chk("instr", instr, m_bdata);
         chk("instr_valid", 16'(instr_valid), 16'(hm));
         chk("stall", 16'(stall), 16'(fe & !hm & !p[0] & !rst));
         chk("misalign", 16'(misalign), 16'(m_mis));
         chk("mem_req", 16'(mem_req), 16'(m_busy));
         chk("mem_addr", mem_addr, m_maddr);
         if (instr_valid === 1'b1) begin
            a1 = p + 16'd1;
            chk("instr_vs_mem", instr, {mem[a1], mem[p]});
         end
      end
      o_stall = stall; o_valid = instr_valid; o_instr = instr;
      if (mem_req === 1'b1) req_cnt++;
      @(posedge clock);
      if (rst) model_reset();
      else begin
         if (fe && p[0]) m_mis = 1;
         if (!m_busy) begin
            if (fe && !hm && !p[0]) begin
               m_busy = 1; m_n = 0; m_faddr = p; m_maddr = p;
            end
         end else if (mem_ack) begin
            if (m_n == 0) begin
               m_lo = mem_rdata; m_n = 1; m_maddr = m_faddr + 16'd1;
            end else begin
               m_bdata = {mem_rdata, m_lo}; m_baddr = m_faddr;
               m_bvalid = 1; m_busy = 0; m_n = 0;
            end
         end
      end
   endtask

   task automatic run_until_hit(input logic [15:0] p, input int limit,
                                output int n);
      int k = 0;
      n = 0;
      do begin
         cycle(1'b0, p, 1'b1);
         if (o_stall) n++;
         k++;
      end while (!o_valid && k < limit);
      if (!o_valid) chk("fill_timeout", 16'(o_valid), 16'd1);
   endtask

   initial begin
      int n;
      logic [15:0] p;
      logic fe, rst;
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      mem[0] = 8'h34; mem[1] = 8'h12;
      mem[16'hFFFE] = 8'hCD; mem[16'hFFFF] = 8'hAB;
      model_reset();

      cycle(1'b1, 16'h0, 1'b0);
      chk_en = 1;
      cycle(1'b1, 16'h0, 1'b1);
      #1;
      chk("rst_instr", instr, 16'h0);
      chk("rst_valid", 16'(instr_valid), 16'h0);
      chk("rst_stall", 16'(stall), 16'h0);
      chk("rst_req", 16'(mem_req), 16'h0);
      chk("rst_addr", mem_addr, 16'h0);

      // zero-wait miss
      alog.delete();
      run_until_hit(16'h0000, 40, n);
      chk("t1_stalls", 16'(n), 16'd3);
      chk("t1_instr", o_instr, 16'h1234);
      chk("t1_nacks", 16'(alog.size()), 16'd2);
      if (alog.size() == 2) begin
         chk("t1_addr0", alog[0], 16'h0000);
         chk("t1_addr1", alog[1], 16'h0001);
      end

      // hold pc: no refetch, then step to 2
      req_cnt = 0;
      repeat (3) cycle(1'b0, 16'h0000, 1'b1);
      chk("t2_norefetch", 16'(req_cnt), 16'd0);
      chk("t2_stall", 16'(o_stall), 16'd0);
      alog.delete();
      run_until_hit(16'h0002, 40, n);
      chk("t2_nacks", 16'(alog.size()), 16'd2);
      if (alog.size() == 2) chk("t2_addr0", alog[0], 16'h0002);

      // waits of 4 and 2
      wq.push_back(4); wq.push_back(2);
      run_until_hit(16'h0004, 60, n);
      chk("t3_stalls", 16'(n), 16'd9);
      chk("t3_instr", o_instr, {mem[5], mem[4]});

      // pc change during fetch
      max_wait = 1;
      alog.delete();
      cycle(1'b0, 16'h0010, 1'b1);
      run_until_hit(16'h0040, 80, n);
      chk("t4_nacks", 16'(alog.size()), 16'd4);
      if (alog.size() == 4) begin
         chk("t4_a0", alog[0], 16'h0010);
         chk("t4_a1", alog[1], 16'h0011);
         chk("t4_a2", alog[2], 16'h0040);
         chk("t4_a3", alog[3], 16'h0041);
      end

      // wrap address and misalign
      max_wait = 0;
      alog.delete();
      run_until_hit(16'hFFFE, 40, n);
      chk("t5_instr", o_instr, 16'hABCD);
      if (alog.size() == 2) begin
         chk("t5_a0", alog[0], 16'hFFFE);
         chk("t5_a1", alog[1], 16'hFFFF);
      end else chk("t5_nacks", 16'(alog.size()), 16'd2);
      req_cnt = 0;
      cycle(1'b0, 16'h0003, 1'b1);
      chk("t5_odd_stall", 16'(o_stall), 16'd0);
      #1;
      chk("t5_mis_set", 16'(misalign), 16'd1);
      repeat (3) cycle(1'b0, 16'h0003, 1'b0);
      chk("t5_no_req", 16'(req_cnt), 16'd0);
      chk("t5_mis_sticky", 16'(misalign), 16'd1);

      // reset in REQ_HI with ack
      cycle(1'b0, 16'h0020, 1'b1);
      cycle(1'b0, 16'h0020, 1'b1);
      cycle(1'b1, 16'h0020, 1'b1);
      #1;
      chk("t6_req", 16'(mem_req), 16'd0);
      chk("t6_instr", instr, 16'h0);
      chk("t6_valid", 16'(instr_valid), 16'd0);
      chk("t6_mis", 16'(misalign), 16'd0);
      cycle(1'b0, 16'h0020, 1'b1);

      // randomized run
      idle_acks = 1;
      max_wait = 3;
      p = 16'h0020;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom % 4 == 0) begin
            if ($urandom % 10 == 0) p = 16'($urandom_range(0, 63)) | 16'd1;
            else if ($urandom % 10 == 0) p = 16'hFFFE;
            else p = 16'($urandom_range(0, 31)) << 1;
         end
         fe = ($urandom % 5 != 0);
         rst = ($urandom % 150 == 0);
         cycle(rst, p, fe);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the LEGLite 16-bit datapath. Takes the current program counter from the PC logic and fetches the 16-bit instruction from an 8-bit-wide instruction memory using a req/ack handshake, one byte per transfer. It keeps the last fetched word in a one-entry buffer tagged by address. While the word for the current pc is not yet available, it asserts `stall` so the PC logic and the rest of the datapath hold.

## Interface

Parameters: none.

- `clock`  in  1  system clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high
- `pc`  in  16  current program counter, byte address, expected even
- `fetch_en`  in  1  core wants an instruction this cycle
- `instr`  out  16  buffered instruction word, {high byte, low byte}
- `instr_valid`  out  1  `instr` corresponds to the current `pc`
- `stall`  out  1  hold PC and datapath; fetch for `pc` is outstanding
- `misalign`  out  1  sticky error: odd `pc` was presented with `fetch_en`
- `mem_addr`  out  16  byte address to instruction memory, registered
- `mem_req`  out  1  read request, registered
- `mem_ack`  in  1  memory returns `mem_rdata` this cycle
- `mem_rdata`  in  8  read byte, valid when `mem_ack`=1

## Operation

- Buffer state: `buf_addr`[15:0], `buf_data`[15:0], `buf_valid`.
- Hit condition: `hit` = `buf_valid` & (`buf_addr` == `pc`). It is computed combinationally.
- `instr_valid` = `hit`, and `instr` = `buf_data` at all times.
- `stall` = `fetch_en` & ~`hit` & ~`pc`[0] & ~`reset`. It is combinational.
- Byte order is little-endian: the byte at `fetch_addr` is the low byte and the byte at `fetch_addr`+1 is the high byte.
- The FSM has three states: IDLE, REQ_LO and REQ_HI.
  - IDLE, on `fetch_en` & ~`hit` & ~`pc`[0]: latch `fetch_addr` <= `pc`, set `mem_addr` <= `pc` and `mem_req` <= 1, go to REQ_LO. Otherwise stay in IDLE with `mem_req` = 0.
  - REQ_LO, on `mem_ack`: `lo_byte` <= `mem_rdata`, `mem_addr` <= `fetch_addr`+1 (16-bit, modulo 2^16), `mem_req` stays 1, go to REQ_HI. With no ack, hold all state.
  - REQ_HI, on `mem_ack`: `buf_data` <= {`mem_rdata`, `lo_byte`}, `buf_addr` <= `fetch_addr`, `buf_valid` <= 1, `mem_req` <= 0, go to IDLE. With no ack, hold all state.
- `mem_ack` is ignored in IDLE.
- Handshake rules:
  - `mem_req` and `mem_addr` are stable until the cycle after `mem_ack`.
  - Back-to-back acks are legal.
  - The memory may hold off ack for any number of cycles.
- A pc change mid-fetch does not abort the fetch. The fetch for the latched `fetch_addr` completes and fills the buffer, then IDLE re-evaluates the hit against the new `pc`.
- The buffer is only overwritten on REQ_HI completion. A `fetch_en` drop mid-fetch does not abort the fetch.
- Misalign: `fetch_en` & `pc`[0] in any state sets `misalign` <= 1. The flag stays set until reset.
  - No fetch is issued for an odd pc.
  - `stall` = 0 and `instr_valid` = 0 for that pc.
- Reset values (reset has priority, including mid-fetch, where any concurrent ack is discarded):
  - state = IDLE
  - `mem_req` = 0, `mem_addr` = 0
  - `buf_valid` = 0, `buf_data` = 0, `buf_addr` = 0
  - `lo_byte` = 0, `fetch_addr` = 0
  - `misalign` = 0
  - Resulting outputs: `instr` = 0, `instr_valid` = 0, `stall` = 0

## Timing

- Miss with zero-wait memory takes 3 stall cycles:
  - cycle 0: miss detected in IDLE, `stall` = 1
  - cycle 1: REQ_LO, ack
  - cycle 2: REQ_HI, ack
  - cycle 3: IDLE, hit, `stall` = 0, `instr_valid` = 1
- Each memory wait cycle adds one stall cycle.
- A hit has zero latency: `instr` is valid in the same cycle `pc` is presented.
- `stall` is combinational from `pc`, `fetch_en` and the buffer registers. The PC logic must treat it as a hold for the next edge.

## Test plan

- Reset, then `pc`=0x0000, `fetch_en`=1, mem bytes [0]=0x34 and [1]=0x12 with immediate acks → `mem_addr` sequence 0x0000 then 0x0001. `stall` is high for 3 cycles, then `instr`=0x1234 and `instr_valid`=1.
- Same `pc` held after the fill → no new `mem_req`, `stall`=0. Step `pc` to 0x0002 → new fetch with `mem_addr`=0x0002.
- Ack delayed 4 cycles on the low byte and 2 on the high byte → `mem_req`/`mem_addr` stable throughout, `stall` high for 9 cycles, correct word captured.
- `pc` changed from 0x0010 to 0x0040 during REQ_LO → fetch of 0x0010/0x0011 completes, `buf_addr`=0x0010, then a new fetch starts at 0x0040. `instr_valid` stays 0 until the 0x0040 fill.
- `pc`=0xFFFE → `mem_addr` is 0xFFFE then 0xFFFF, word assembled correctly. `pc`=0x0003 with `fetch_en` → `misalign`=1 and stays set, no `mem_req`, `stall`=0.
- Reset asserted in REQ_HI with `mem_ack`=1 → next cycle state is IDLE, `mem_req`=0, `buf_valid`=0, `instr`=0, and the ack data is discarded.
